// File: rtl/usbdev_in_ep_ctrl_if.sv
// rtl/usbdev_in_ep_ctrl_if.sv - packet SRAM read port between the IN endpoint controller and the SRAM
//
// Purpose: groups the word-read request/grant/response signals of the shared packet SRAM.
// Signals:
//   mem_req    request, held with a stable address until granted
//   mem_addr   word address {buffer id, word index}
//   mem_gnt    request accepted this cycle
//   mem_rvalid read data valid (one response per granted request)
//   mem_rdata  32-bit little-endian packet word
// Modports: master = requester (endpoint controller), slave = SRAM side.
interface usbdev_in_ep_ctrl_if #(
  parameter int MemAddrW = 9
);
  logic                mem_req;
  logic [MemAddrW-1:0] mem_addr;
  logic                mem_gnt;
  logic                mem_rvalid;
  logic [31:0]         mem_rdata;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_gnt,
    input  mem_rvalid,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_gnt,
    output mem_rvalid,
    output mem_rdata
  );
endinterface

// File: rtl/usbdev_in_ep_ctrl.sv
// rtl/usbdev_in_ep_ctrl.sv - per-endpoint IN buffer controller with packet SRAM word fetch
//
// Purpose: holds buffer id / size / ready per IN endpoint, snapshots the selected endpoint when
// the IN engine starts a transaction, serves payload bytes out of a one-word cache filled from
// the packet SRAM, and retires endpoints (pkt_sent pulse) on a good transaction end.
// Ports:
//   clk_48mhz_i, rst_ni        clock, async active-low reset
//   link_reset_i               synchronous clear on USB bus reset
//   cfg_*                      software endpoint configuration write
//   rdy_o, pkt_sent_o          ready bits, one-cycle delivered pulses
//   in_xact_*, in_ep_*         IN protocol engine interface
//   mem                        packet SRAM read port (master side)
module usbdev_in_ep_ctrl #(
  parameter int NumInEps         = 12,
  parameter int MaxInPktSizeByte = 64,
  parameter int NumBuffers       = 32,
  parameter int BufW             = $clog2(NumBuffers),
  parameter int PktW             = $clog2(MaxInPktSizeByte),
  parameter int SizeW            = PktW + 1,
  parameter int MemAddrW         = BufW + PktW - 2
) (
  input  logic                clk_48mhz_i,
  input  logic                rst_ni,
  input  logic                link_reset_i,
  input  logic                cfg_we_i,
  input  logic [3:0]          cfg_ep_i,
  input  logic [BufW-1:0]     cfg_buf_i,
  input  logic [SizeW-1:0]    cfg_size_i,
  input  logic                cfg_rdy_i,
  output logic [NumInEps-1:0] rdy_o,
  output logic [NumInEps-1:0] pkt_sent_o,
  input  logic                in_xact_starting_i,
  input  logic [3:0]          in_xact_start_ep_i,
  input  logic [3:0]          in_ep_current_i,
  input  logic [PktW-1:0]     in_ep_get_addr_i,
  input  logic                in_ep_data_get_i,
  input  logic                in_ep_xact_end_i,
  input  logic                in_ep_rollback_i,
  output logic [NumInEps-1:0] in_ep_has_data_o,
  output logic [NumInEps-1:0] in_ep_data_done_o,
  output logic [7:0]          in_ep_data_o,
  usbdev_in_ep_ctrl_if.master mem
);

  localparam logic [3:0]       NumEpsL = 4'(NumInEps);
  localparam logic [SizeW-1:0] MaxSize = SizeW'(MaxInPktSizeByte);

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StWait
  } state_e;

  state_e r_state;
  state_e w_state_nxt;

  logic [NumInEps-1:0] r_rdy;
  logic [BufW-1:0]     r_buf  [NumInEps];
  logic [SizeW-1:0]    r_size [NumInEps];
  logic [NumInEps-1:0] r_pkt_sent;

  logic [BufW-1:0]     r_cur_buf;
  logic [SizeW-1:0]    r_cur_size;
  logic [SizeW-1:0]    r_byte_cnt;
  logic [31:0]         r_word;
  logic [PktW-3:0]     r_word_tag;
  logic                r_word_vld;
  logic [MemAddrW-1:0] r_req_addr;
  // Set when a snapshot/rollback lands while a fetch is outstanding: its data belongs
  // to a packet state that no longer exists and must not fill the word cache.
  logic                r_discard;

  logic                w_cfg_valid;
  logic                w_cur_valid;
  logic                w_start_valid;
  logic [SizeW-1:0]    w_cfg_size;
  logic                w_flush;
  logic [PktW-3:0]     w_word_idx;
  logic                w_need_word;
  logic                w_mem_req;
  logic                w_req_load;
  logic                w_capture;

  assign w_cfg_valid   = cfg_ep_i < NumEpsL;
  assign w_cur_valid   = in_ep_current_i < NumEpsL;
  assign w_start_valid = in_xact_start_ep_i < NumEpsL;
  assign w_cfg_size    = (cfg_size_i > MaxSize) ? MaxSize : cfg_size_i;
  assign w_flush       = in_xact_starting_i | in_ep_rollback_i;
  assign w_word_idx    = in_ep_get_addr_i[PktW-1:2];
  assign w_need_word   = (r_byte_cnt < r_cur_size) &&
                         (!r_word_vld || (r_word_tag != w_word_idx));

  // Fetch FSM: state register
  always_ff @(posedge clk_48mhz_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Fetch FSM: next state and request control
  always_comb begin
    w_state_nxt = r_state;
    w_mem_req   = 1'b0;
    w_req_load  = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      StIdle: begin
        // Hold off during a snapshot/rollback cycle so the request uses the new packet state.
        if (w_need_word && !w_flush) begin
          w_state_nxt = StReq;
          w_req_load  = 1'b1;
        end
      end
      StReq: begin
        w_mem_req = 1'b1;
        if (mem.mem_gnt) begin
          w_state_nxt = StWait;
        end
      end
      StWait: begin
        if (mem.mem_rvalid) begin
          w_state_nxt = StIdle;
          w_capture   = !w_flush && !r_discard;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
    if (link_reset_i) begin
      w_state_nxt = StIdle;
      w_req_load  = 1'b0;
      w_capture   = 1'b0;
    end
  end

  always_ff @(posedge clk_48mhz_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rdy      <= '0;
      r_pkt_sent <= '0;
      for (int i = 0; i < NumInEps; i++) begin
        r_buf[i]  <= '0;
        r_size[i] <= '0;
      end
      r_cur_buf  <= '0;
      r_cur_size <= '0;
      r_byte_cnt <= '0;
      r_word     <= '0;
      r_word_tag <= '0;
      r_word_vld <= 1'b0;
      r_req_addr <= '0;
      r_discard  <= 1'b0;
    end else if (link_reset_i) begin
      r_rdy      <= '0;
      r_pkt_sent <= '0;
      for (int i = 0; i < NumInEps; i++) begin
        r_buf[i]  <= '0;
        r_size[i] <= '0;
      end
      r_cur_buf  <= '0;
      r_cur_size <= '0;
      r_byte_cnt <= '0;
      r_word     <= '0;
      r_word_tag <= '0;
      r_word_vld <= 1'b0;
      r_req_addr <= '0;
      r_discard  <= 1'b0;
    end else begin
      r_pkt_sent <= '0;
      if (in_ep_xact_end_i && w_cur_valid) begin
        r_rdy[in_ep_current_i]      <= 1'b0;
        r_pkt_sent[in_ep_current_i] <= 1'b1;
      end
      // Placed after the retire so a same-cycle write to that endpoint wins.
      if (cfg_we_i && w_cfg_valid) begin
        r_buf[cfg_ep_i]  <= cfg_buf_i;
        r_size[cfg_ep_i] <= w_cfg_size;
        r_rdy[cfg_ep_i]  <= cfg_rdy_i;
      end

      if (in_xact_starting_i) begin
        r_cur_buf  <= w_start_valid ? r_buf[in_xact_start_ep_i]  : '0;
        r_cur_size <= w_start_valid ? r_size[in_xact_start_ep_i] : '0;
        r_byte_cnt <= '0;
        r_word_vld <= 1'b0;
      end else begin
        if (in_ep_data_get_i && (r_byte_cnt < MaxSize)) begin
          r_byte_cnt <= r_byte_cnt + 1'b1;
        end
        if (in_ep_rollback_i) begin
          r_word_vld <= 1'b0;
        end else if (w_capture) begin
          r_word     <= mem.mem_rdata;
          r_word_tag <= r_req_addr[PktW-3:0];
          r_word_vld <= 1'b1;
        end
      end

      if (w_req_load) begin
        r_req_addr <= {r_cur_buf, w_word_idx};
        r_discard  <= 1'b0;
      end else if (w_flush && (r_state != StIdle)) begin
        r_discard  <= 1'b1;
      end
    end
  end

  always_comb begin
    in_ep_data_done_o = '0;
    if (w_cur_valid) begin
      in_ep_data_done_o[in_ep_current_i] = (r_byte_cnt >= r_cur_size);
    end
  end

  assign rdy_o            = r_rdy;
  assign in_ep_has_data_o = r_rdy;
  assign pkt_sent_o       = r_pkt_sent;
  assign in_ep_data_o     = r_word[{in_ep_get_addr_i[1:0], 3'b000} +: 8];
  assign mem.mem_req      = w_mem_req;
  assign mem.mem_addr     = r_req_addr;

endmodule

// File: tb/tb_usbdev_in_ep_ctrl.sv
// tb/tb_usbdev_in_ep_ctrl.sv - scoreboard testbench for usbdev_in_ep_ctrl
module tb_usbdev_in_ep_ctrl;
  localparam int BYTE_CLKS = 20;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        link_reset = 1'b0;
  logic        cfg_we = 1'b0;
  logic [3:0]  cfg_ep = '0;
  logic [4:0]  cfg_buf = '0;
  logic [6:0]  cfg_size = '0;
  logic        cfg_rdy = 1'b0;
  logic [11:0] rdy_o;
  logic [11:0] pkt_sent_o;
  logic        in_xact_starting = 1'b0;
  logic [3:0]  in_xact_start_ep = '0;
  logic [3:0]  in_ep_current = '0;
  logic [5:0]  in_ep_get_addr = '0;
  logic        in_ep_data_get = 1'b0;
  logic        in_ep_xact_end = 1'b0;
  logic        in_ep_rollback = 1'b0;
  logic [11:0] in_ep_has_data;
  logic [11:0] in_ep_data_done;
  logic [7:0]  in_ep_data;

  usbdev_in_ep_ctrl_if #(.MemAddrW(9)) mif ();

  usbdev_in_ep_ctrl dut (
    .clk_48mhz_i        (clk),
    .rst_ni             (rst_n),
    .link_reset_i       (link_reset),
    .cfg_we_i           (cfg_we),
    .cfg_ep_i           (cfg_ep),
    .cfg_buf_i          (cfg_buf),
    .cfg_size_i         (cfg_size),
    .cfg_rdy_i          (cfg_rdy),
    .rdy_o              (rdy_o),
    .pkt_sent_o         (pkt_sent_o),
    .in_xact_starting_i (in_xact_starting),
    .in_xact_start_ep_i (in_xact_start_ep),
    .in_ep_current_i    (in_ep_current),
    .in_ep_get_addr_i   (in_ep_get_addr),
    .in_ep_data_get_i   (in_ep_data_get),
    .in_ep_xact_end_i   (in_ep_xact_end),
    .in_ep_rollback_i   (in_ep_rollback),
    .in_ep_has_data_o   (in_ep_has_data),
    .in_ep_data_done_o  (in_ep_data_done),
    .in_ep_data_o       (in_ep_data),
    .mem                (mif)
  );

  always #10 clk = ~clk;

  // Reference model state
  logic [31:0] mem_model [512];
  int          model_buf  [12];
  int          model_size [12];
  logic [11:0] exp_rdy = '0;
  logic [4:0]  exp_buf = '0;
  logic [7:0]  exp_data_q [$];
  logic [11:0] exp_pkt_q [$];

  int vectors = 0;
  int miscompares = 0;

  int gnt_delay = 0;
  int rvalid_delay = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // SRAM responder: grant after gnt_delay request cycles, data rvalid_delay cycles after grant.
  initial begin
    int g_cnt;
    int rv_cnt;
    bit rv_pending;
    logic [8:0] rv_addr;
    g_cnt = 0; rv_cnt = 0; rv_pending = 0; rv_addr = '0;
    mif.mem_gnt = 1'b0;
    mif.mem_rvalid = 1'b0;
    mif.mem_rdata = '0;
    forever begin
      tick();
      mif.mem_gnt = 1'b0;
      mif.mem_rvalid = 1'b0;
      if (rv_pending) begin
        if (rv_cnt == 0) begin
          mif.mem_rvalid = 1'b1;
          mif.mem_rdata = mem_model[rv_addr];
          rv_pending = 0;
        end else begin
          rv_cnt--;
        end
      end else if (mif.mem_req) begin
        if (g_cnt >= gnt_delay) begin
          mif.mem_gnt = 1'b1;
          rv_pending = 1;
          rv_addr = mif.mem_addr;
          rv_cnt = rvalid_delay;
          g_cnt = 0;
        end else begin
          g_cnt++;
        end
      end else begin
        g_cnt = 0;
      end
    end
  end

  // Monitor: pops expectations whenever the DUT presents a byte, a pulse or a granted fetch.
  always @(negedge clk) begin
    if (rst_n) begin
      if (in_ep_data_get) begin
        if (exp_data_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL data_unexpected: got 0x%0h with no expected byte", in_ep_data);
        end else begin
          check("data_byte", in_ep_data, exp_data_q.pop_front());
        end
      end
      if (pkt_sent_o != '0) begin
        if (exp_pkt_q.size() == 0) begin
          check("pkt_sent_extra", pkt_sent_o, 12'h0);
        end else begin
          check("pkt_sent", pkt_sent_o, exp_pkt_q.pop_front());
        end
      end
      if (mif.mem_req && mif.mem_gnt) begin
        check("mem_addr", mif.mem_addr, {exp_buf, in_ep_get_addr[5:2]});
      end
    end
  end

  task automatic cfg_write(input int ep, input int b, input int sz, input bit rdy);
    tick();
    cfg_we = 1'b1; cfg_ep = 4'(ep); cfg_buf = 5'(b); cfg_size = 7'(sz); cfg_rdy = rdy;
    tick();
    cfg_we = 1'b0;
    if (ep < 12) begin
      model_buf[ep] = b;
      model_size[ep] = (sz > 64) ? 64 : sz;
      exp_rdy[ep] = rdy;
    end
    @(negedge clk);
    check("rdy_after_cfg", rdy_o, exp_rdy);
  endtask

  task automatic do_xact(input int ep, input int nread, input bit good,
                         input bit recfg, input bit same_cfg, input int hold);
    int sz;
    int b;
    int t;
    int nb;
    int ns;
    logic [31:0] w;
    logic [11:0] onehot;
    sz = model_size[ep];
    b = model_buf[ep];
    onehot = 12'h1 << ep;
    tick();
    in_xact_starting = 1'b1; in_xact_start_ep = 4'(ep); in_ep_current = 4'(ep);
    in_ep_get_addr = '0; exp_buf = 5'(b);
    tick();
    in_xact_starting = 1'b0;
    @(negedge clk);
    check("done_at_start", in_ep_data_done, (sz == 0) ? onehot : 12'h0);
    if (sz == 0) begin
      for (int k = 0; k < 4; k++) begin
        check("no_req_size0", mif.mem_req, 1'b0);
        @(negedge clk);
      end
    end
    if (hold > 0) begin
      t = 0;
      while (!mif.mem_req && t < 10) begin
        @(negedge clk);
        t++;
      end
      check("hold_req_seen", mif.mem_req, 1'b1);
      for (int k = 0; k < hold; k++) begin
        check("hold_req", mif.mem_req, 1'b1);
        check("hold_addr", mif.mem_addr, {exp_buf, 4'd0});
        @(negedge clk);
      end
    end
    if (recfg) cfg_write(ep, $urandom_range(0, 31), $urandom_range(0, 80), 1'b1);
    for (int i = 0; i < nread; i++) begin
      tick();
      in_ep_get_addr = 6'(i);
      repeat (BYTE_CLKS) tick();
      w = mem_model[b * 16 + i / 4];
      exp_data_q.push_back(8'(w >> (8 * (i % 4))));
      in_ep_data_get = 1'b1;
      tick();
      in_ep_data_get = 1'b0;
    end
    @(negedge clk);
    check("done_after_reads", in_ep_data_done, (nread >= sz) ? onehot : 12'h0);
    tick();
    if (good) begin
      in_ep_xact_end = 1'b1;
      exp_pkt_q.push_back(onehot);
      exp_rdy[ep] = 1'b0;
      if (same_cfg) begin
        nb = $urandom_range(0, 31);
        ns = $urandom_range(0, 80);
        cfg_we = 1'b1; cfg_ep = 4'(ep); cfg_buf = 5'(nb); cfg_size = 7'(ns); cfg_rdy = 1'b1;
        model_buf[ep] = nb;
        model_size[ep] = (ns > 64) ? 64 : ns;
        exp_rdy[ep] = 1'b1;
      end
      tick();
      in_ep_xact_end = 1'b0;
      cfg_we = 1'b0;
    end else begin
      in_ep_rollback = 1'b1;
      in_ep_get_addr = '0;
      tick();
      in_ep_rollback = 1'b0;
    end
    @(negedge clk);
    check("rdy_after_end", rdy_o, exp_rdy);
    check("has_data", in_ep_has_data, exp_rdy);
  endtask

  initial begin
    int ep;
    int esz;
    int t;
    for (int i = 0; i < 512; i++) mem_model[i] = $urandom();
    mem_model[80] = 32'h44332211;
    mem_model[112] = 32'hA5A5A5A5;
    for (int i = 0; i < 12; i++) begin
      model_buf[i] = 0;
      model_size[i] = 0;
    end
    repeat (3) tick();
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_rdy", rdy_o, 12'h0);
    check("reset_pkt_sent", pkt_sent_o, 12'h0);
    check("reset_mem_req", mif.mem_req, 1'b0);
    check("reset_data", in_ep_data, 8'h00);
    check("reset_done", in_ep_data_done, 12'h001);

    // Basic 3-byte packet from buffer 5
    cfg_write(2, 5, 3, 1'b1);
    check("rdy_ep2", rdy_o, 12'h004);
    do_xact(2, 3, 1'b1, 1'b0, 1'b0, 0);
    check("rdy_ep2_cleared", rdy_o, 12'h000);

    // Zero-length packet
    cfg_write(1, 9, 0, 1'b1);
    do_xact(1, 0, 1'b1, 1'b0, 1'b0, 0);

    // Slow grant with a word crossing
    gnt_delay = 10;
    cfg_write(3, 9, 8, 1'b1);
    do_xact(3, 8, 1'b1, 1'b0, 1'b0, 10);
    gnt_delay = 0;

    // Rollback after 2 bytes, then full retry
    cfg_write(7, 11, 10, 1'b1);
    do_xact(7, 2, 1'b0, 1'b0, 1'b0, 0);
    do_xact(7, 10, 1'b1, 1'b0, 1'b0, 0);

    // Retire and reconfigure the same endpoint in one cycle
    cfg_write(4, 2, 5, 1'b1);
    do_xact(4, 5, 1'b1, 1'b0, 1'b1, 0);

    // Out-of-range endpoint write is ignored
    cfg_write(13, 3, 4, 1'b1);
    cfg_write(12, 3, 4, 1'b1);

    // Randomized traffic
    for (int n = 0; n < 14; n++) begin
      ep = $urandom_range(0, 11);
      gnt_delay = $urandom_range(0, 4);
      rvalid_delay = $urandom_range(0, 2);
      if ($urandom_range(0, 3) == 0) cfg_write($urandom_range(12, 15), $urandom_range(0, 31), 5, 1'b1);
      if ($urandom_range(0, 3) == 0) cfg_write($urandom_range(0, 11), $urandom_range(0, 31), 7, 1'b0);
      cfg_write(ep, $urandom_range(0, 31), $urandom_range(0, 80), 1'b1);
      esz = model_size[ep];
      if (esz >= 2 && $urandom_range(0, 2) == 0) begin
        do_xact(ep, $urandom_range(1, esz - 1), 1'b0, 1'b0, 1'b0, 0);
      end
      do_xact(ep, esz, 1'b1, 1'(($urandom_range(0, 1))), $urandom_range(0, 3) == 0, 0);
    end
    gnt_delay = 0;

    // Bus reset while a fetch is waiting for data
    rvalid_delay = 6;
    cfg_write(6, 7, 4, 1'b1);
    tick();
    in_xact_starting = 1'b1; in_xact_start_ep = 4'd6; in_ep_current = 4'd6;
    in_ep_get_addr = '0; exp_buf = 5'd7;
    tick();
    in_xact_starting = 1'b0;
    t = 0;
    @(negedge clk);
    while (!mif.mem_gnt && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("lr_gnt_seen", mif.mem_gnt, 1'b1);
    tick();
    link_reset = 1'b1;
    tick();
    link_reset = 1'b0;
    exp_rdy = '0;
    for (int i = 0; i < 12; i++) begin
      model_buf[i] = 0;
      model_size[i] = 0;
    end
    @(negedge clk);
    check("lr_rdy", rdy_o, 12'h0);
    check("lr_has_data", in_ep_has_data, 12'h0);
    for (int k = 0; k < 12; k++) begin
      check("lr_data_stable", in_ep_data, 8'h00);
      check("lr_no_req", mif.mem_req, 1'b0);
      @(negedge clk);
    end
    rvalid_delay = 0;

    repeat (4) @(negedge clk);
    check("data_queue_drained", 64'(exp_data_q.size()), 64'd0);
    check("pkt_queue_drained", 64'(exp_pkt_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
    $fatal(1);
  end
endmodule
